// File: rtl/cfifo_n_if.sv
// Handshake bundle for cfifo_n: sender side, receiver side, and per-stage fire pulses.
// The o_count member exists only when CFIFO_OCC_COUNT_EN is defined.
interface cfifo_n_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  logic             i_drive;
  logic [WIDTH-1:0] i_data;
  logic             o_free;
  logic             o_driveNext;
  logic [WIDTH-1:0] o_data;
  logic             i_freeNext;
  logic [DEPTH-1:0] o_fire;
`ifdef CFIFO_OCC_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] o_count;

  modport master (
    output i_drive, i_data, i_freeNext,
    input  o_free, o_driveNext, o_data, o_fire, o_count
  );
  modport slave (
    input  i_drive, i_data, i_freeNext,
    output o_free, o_driveNext, o_data, o_fire, o_count
  );
`else
  modport master (
    output i_drive, i_data, i_freeNext,
    input  o_free, o_driveNext, o_data, o_fire
  );
  modport slave (
    input  i_drive, i_data, i_freeNext,
    output o_free, o_driveNext, o_data, o_fire
  );
`endif
endinterface

// File: rtl/cfifo_n.sv
// Clocked click-style relay FIFO: DEPTH stages, one token per stage, moves decided from current state only.
// Optional occupancy counter on bus.o_count enabled by CFIFO_OCC_COUNT_EN.
module cfifo_n #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input logic       clk,
  input logic       rst,
  cfifo_n_if.slave  bus
);

  generate
    if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
      $error("cfifo_n: DEPTH must be in 2..16");
    end
  endgenerate

  logic [DEPTH-1:0] full_r;
  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] fire_s;
  logic [DEPTH-1:0] take_s;
  logic [DEPTH-1:0] full_nxt_s;
  logic [WIDTH-1:0] src_s [DEPTH];
  logic             drain_s;

  // A stage fires only if empty now; reset suppresses every move.
  always_comb begin
    fire_s    = {DEPTH{1'b0}};
    fire_s[0] = bus.i_drive & ~full_r[0] & ~rst;
    for (int k = 1; k < DEPTH; k++) begin
      fire_s[k] = full_r[k-1] & ~full_r[k] & ~rst;
    end
    drain_s    = full_r[DEPTH-1] & bus.i_freeNext & ~rst;
    take_s     = {drain_s, fire_s[DEPTH-1:1]};
    full_nxt_s = fire_s | (full_r & ~take_s);
    src_s[0]   = bus.i_data;
    for (int k = 1; k < DEPTH; k++) begin
      src_s[k] = data_r[k-1];
    end
  end

  // Stage full flags and token data.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      full_r <= full_nxt_s;
      for (int k = 0; k < DEPTH; k++) begin
        if (fire_s[k]) begin
          data_r[k] <= src_s[k];
        end else begin
          data_r[k] <= data_r[k];
        end
      end
    end
  end

  assign bus.o_free      = ~full_r[0];
  assign bus.o_driveNext = full_r[DEPTH-1];
  assign bus.o_data      = data_r[DEPTH-1];
  assign bus.o_fire      = fire_s;

`ifdef CFIFO_OCC_COUNT_EN
  localparam int CW = $clog2(DEPTH+1);
  logic [CW-1:0] count_r;

  // Occupancy: accept and drain in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (fire_s[0] && !drain_s) begin
      count_r <= count_r + CW'(1);
    end else if (drain_s && !fire_s[0]) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.o_count = count_r;
`endif

endmodule
